// File: rtl/magnitud_iq.sv
// rtl/magnitud_iq.sv - I/Q magnitude front end: serial I^2+Q^2, then START/FIN handshake with the 32->16 root stage.
module magnitud_iq (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [15:0] I,
  input  logic [15:0] Q,
  output logic        FIN,
  output logic [15:0] MAG,
  output logic [31:0] SUMSQ,
  output logic [31:0] SQ_X,
  output logic        SQ_START,
  input  logic        SQ_FIN,
  input  logic [15:0] SQ_COUNT
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_MUL      = 3'd2;
  localparam logic [2:0] S_SUM      = 3'd3;
  localparam logic [2:0] S_ROOT_REQ = 3'd4;
  localparam logic [2:0] S_ROOT_REL = 3'd5;
  localparam logic [2:0] S_FINALI   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] i_q, i_d, q_q, q_d;
  logic [31:0] mcand_i_q, mcand_i_d, mcand_q_q, mcand_q_d;
  logic [15:0] mplier_i_q, mplier_i_d, mplier_q_q, mplier_q_d;
  logic [31:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] sumsq_q, sumsq_d;
  logic [15:0] mag_q, mag_d;
  logic [15:0] abs_i, abs_q;

  // Two's-complement negate keeps -32768 exact as 0x8000 in 16 unsigned bits.
  assign abs_i = i_q[15] ? (~i_q + 16'd1) : i_q;
  assign abs_q = q_q[15] ? (~q_q + 16'd1) : q_q;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    q_d        = q_q;
    mcand_i_d  = mcand_i_q;
    mcand_q_d  = mcand_q_q;
    mplier_i_d = mplier_i_q;
    mplier_q_d = mplier_q_q;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    cnt_d      = cnt_q;
    sumsq_d    = sumsq_q;
    mag_d      = mag_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          i_d     = I;
          q_d     = Q;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        mcand_i_d  = {16'd0, abs_i};
        mcand_q_d  = {16'd0, abs_q};
        mplier_i_d = abs_i;
        mplier_q_d = abs_q;
        acc_i_d    = 32'd0;
        acc_q_d    = 32'd0;
        cnt_d      = 4'd0;
        state_d    = S_MUL;
      end
      S_MUL: begin
        acc_i_d    = acc_i_q + (mplier_i_q[0] ? mcand_i_q : 32'd0);
        acc_q_d    = acc_q_q + (mplier_q_q[0] ? mcand_q_q : 32'd0);
        mcand_i_d  = mcand_i_q << 1;
        mcand_q_d  = mcand_q_q << 1;
        mplier_i_d = mplier_i_q >> 1;
        mplier_q_d = mplier_q_q >> 1;
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_SUM;
      end
      S_SUM: begin
        sumsq_d = acc_i_q + acc_q_q;
        state_d = S_ROOT_REQ;
      end
      S_ROOT_REQ: begin
        if (SQ_FIN) begin
          mag_d   = SQ_COUNT;
          state_d = S_ROOT_REL;
        end
      end
      // Wait for the root stage to drop FIN so it is idle before any new request.
      S_ROOT_REL: begin
        if (!SQ_FIN) state_d = S_FINALI;
      end
      S_FINALI: begin
        if (!START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      i_q        <= 16'd0;
      q_q        <= 16'd0;
      mcand_i_q  <= 32'd0;
      mcand_q_q  <= 32'd0;
      mplier_i_q <= 16'd0;
      mplier_q_q <= 16'd0;
      acc_i_q    <= 32'd0;
      acc_q_q    <= 32'd0;
      cnt_q      <= 4'd0;
      sumsq_q    <= 32'd0;
      mag_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      q_q        <= q_d;
      mcand_i_q  <= mcand_i_d;
      mcand_q_q  <= mcand_q_d;
      mplier_i_q <= mplier_i_d;
      mplier_q_q <= mplier_q_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      cnt_q      <= cnt_d;
      sumsq_q    <= sumsq_d;
      mag_q      <= mag_d;
    end
  end

  assign FIN      = (state_q == S_FINALI);
  assign SQ_START = (state_q == S_ROOT_REQ);
  assign MAG      = mag_q;
  assign SUMSQ    = sumsq_q;
  assign SQ_X     = sumsq_q;

endmodule
